// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package seq_div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_div_step.sv
// One combinational restoring-division step: shift {rem, quo} left and trial-subtract.
module seq_div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvsr,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] diff_s;

  assign shifted_s = {rem[WIDTH-1:0], quo[WIDTH-1]};
  assign diff_s    = shifted_s - {1'b0, dvsr};

  // MSB of the WIDTH+1 bit difference flags a negative trial result
  always_comb begin
    rem_next = shifted_s;
    quo_next = {quo[WIDTH-2:0], 1'b0};
    if (!diff_s[WIDTH]) begin
      rem_next = diff_s;
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted_s;
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_div_ctrl.sv
// Multi-cycle signed/unsigned restoring divider with FSM controller.
// Optional macro DIV_ZERO_CHECK_EN adds the div_by_zero port and a one-cycle zero-divisor path.
module seq_div_ctrl
  import seq_div_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
`ifdef DIV_ZERO_CHECK_EN
  ,
  output logic             div_by_zero
`endif
);

  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
    return ~x + ONE;
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
`ifdef DIV_ZERO_CHECK_EN
  logic             dbz_q, dbz_d;
  logic             dbz_pend_q, dbz_pend_d;
`endif

  logic [WIDTH:0]   step_rem_s;
  logic [WIDTH-1:0] step_quo_s;
  logic             a_neg_s, b_neg_s;

  seq_div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .dvsr     (dvsr_q),
    .rem_next (step_rem_s),
    .quo_next (step_quo_s)
  );

  assign a_neg_s = signed_mode & dividend[WIDTH-1];
  assign b_neg_s = signed_mode & divisor[WIDTH-1];

  // Next-state and datapath computation for every register
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
`ifdef DIV_ZERO_CHECK_EN
    dbz_d       = dbz_q;
    dbz_pend_d  = dbz_pend_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          quo_d   = a_neg_s ? neg(dividend) : dividend;
          dvsr_d  = b_neg_s ? neg(divisor) : divisor;
          q_neg_d = a_neg_s ^ b_neg_s;
          r_neg_d = a_neg_s;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = S_CALC;
`ifdef DIV_ZERO_CHECK_EN
          dbz_d = 1'b0;
          // Zero divisor skips the iterations; raw dividend rides in quo for FIX
          if (divisor == '0) begin
            quo_d      = dividend;
            dbz_pend_d = 1'b1;
            state_d    = S_FIX;
          end else begin
            dbz_pend_d = 1'b0;
          end
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        rem_d = step_rem_s;
        quo_d = step_quo_s;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == LAST_STEP) begin
          state_d = S_FIX;
        end else begin
          state_d = S_CALC;
        end
      end
      S_FIX: begin
        quotient_d  = q_neg_q ? neg(quo_q) : quo_q;
        remainder_d = r_neg_q ? neg(rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
        done_d      = 1'b1;
        state_d     = S_IDLE;
`ifdef DIV_ZERO_CHECK_EN
        if (dbz_pend_q) begin
          quotient_d  = '1;
          remainder_d = quo_q;
          dbz_d       = 1'b1;
          dbz_pend_d  = 1'b0;
        end else begin
          dbz_d = 1'b0;
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
`ifdef DIV_ZERO_CHECK_EN
      dbz_q       <= 1'b0;
      dbz_pend_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
`ifdef DIV_ZERO_CHECK_EN
      dbz_q       <= dbz_d;
      dbz_pend_q  <= dbz_pend_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
`ifdef DIV_ZERO_CHECK_EN
  assign div_by_zero = dbz_q;
`endif

endmodule

// File: tb/tb_seq_div_ctrl.sv
// Directed, table-driven bench for seq_div_ctrl (WIDTH=8); honours DIV_ZERO_CHECK_EN.
module tb_seq_div_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       signed_mode;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
`ifdef DIV_ZERO_CHECK_EN
  logic       div_by_zero;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  seq_div_ctrl #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_mode (signed_mode),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder)
`ifdef DIV_ZERO_CHECK_EN
    ,
    .div_by_zero (div_by_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       sm;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_q;
    logic [7:0] exp_r;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive a request so the next rising edge samples it; returns #1 after that edge.
  task automatic issue(input logic sm, input logic [7:0] a, input logic [7:0] b);
    start       = 1'b1;
    signed_mode = sm;
    dividend    = a;
    divisor     = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 8'h5A;
    divisor  = 8'h3C;
  endtask

  // Count edges after the accepting edge until done, bounded.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  int lat, bcnt, lat2;
  logic saw_done;

  initial begin
    vecs[0] = '{1'b1, 8'hF3, 8'h05, 8'hFE, 8'hFD};  // -13 / 5
    vecs[1] = '{1'b0, 8'hF3, 8'h05, 8'h30, 8'h03};  // 243 / 5
    vecs[2] = '{1'b1, 8'h80, 8'hFF, 8'h80, 8'h00};  // -128 / -1
    vecs[3] = '{1'b1, 8'h07, 8'hFE, 8'hFD, 8'h01};  // 7 / -2
    vecs[4] = '{1'b1, 8'hF9, 8'h02, 8'hFD, 8'hFF};  // -7 / 2
    vecs[5] = '{1'b0, 8'h64, 8'h07, 8'h0E, 8'h02};  // 100 / 7
    vecs[6] = '{1'b0, 8'hFF, 8'h01, 8'hFF, 8'h00};  // 255 / 1
    vecs[7] = '{1'b0, 8'h80, 8'hFF, 8'h00, 8'h80};  // 128 / 255
    vecs[8] = '{1'b1, 8'h7F, 8'h80, 8'h00, 8'h7F};  // 127 / -128
    vecs[9] = '{1'b1, 8'h80, 8'h07, 8'hEE, 8'hFE};  // -128 / 7

    rst_n       = 1'b0;
    start       = 1'b0;
    signed_mode = 1'b0;
    dividend    = 8'h00;
    divisor     = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_quo", {24'd0, quotient}, 32'd0);
    chk("reset_rem", {24'd0, remainder}, 32'd0);
`ifdef DIV_ZERO_CHECK_EN
    chk("reset_dbz", {31'd0, div_by_zero}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      issue(vecs[i].sm, vecs[i].a, vecs[i].b);
      wait_done(lat, bcnt);
      chk($sformatf("vec%0d_latency", i), lat, 32'd9);
      chk($sformatf("vec%0d_busy_cycles", i), bcnt, 32'd9);
      chk($sformatf("vec%0d_busy_at_done", i), {31'd0, busy}, 32'd0);
      chk($sformatf("vec%0d_quo", i), {24'd0, quotient}, {24'd0, vecs[i].exp_q});
      chk($sformatf("vec%0d_rem", i), {24'd0, remainder}, {24'd0, vecs[i].exp_r});
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_done_pulse", i), {31'd0, done}, 32'd0);
    end

    // start pulsed mid-CALC with different operands is ignored
    @(negedge clk);
    issue(1'b0, 8'd100, 8'd7);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    issue(1'b1, 8'd200, 8'd3);
    wait_done(lat, bcnt);
    chk("midcalc_latency", lat + 4, 32'd9);
    chk("midcalc_quo", {24'd0, quotient}, 32'd14);
    chk("midcalc_rem", {24'd0, remainder}, 32'd2);

    // back-to-back: new start in the done cycle
    @(negedge clk);
    issue(1'b1, 8'hF3, 8'h05);
    wait_done(lat, bcnt);
    chk("b2b_first_quo", {24'd0, quotient}, 32'hFE);
    issue(1'b0, 8'hF3, 8'h05);
    chk("b2b_held_quo", {24'd0, quotient}, 32'hFE);
    chk("b2b_held_rem", {24'd0, remainder}, 32'hFD);
    wait_done(lat, bcnt);
    chk("b2b_second_latency", lat, 32'd9);
    chk("b2b_second_quo", {24'd0, quotient}, 32'd48);
    chk("b2b_second_rem", {24'd0, remainder}, 32'd3);

    // reset for one cycle during CALC aborts the operation
    @(negedge clk);
    issue(1'b0, 8'hF3, 8'h05);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_quo", {24'd0, quotient}, 32'd0);
    chk("abort_rem", {24'd0, remainder}, 32'd0);
    saw_done = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    chk("abort_no_done", {31'd0, saw_done}, 32'd0);
    @(negedge clk);
    issue(1'b0, 8'd100, 8'd7);
    wait_done(lat, bcnt);
    chk("post_abort_latency", lat, 32'd9);
    chk("post_abort_quo", {24'd0, quotient}, 32'd14);
    chk("post_abort_rem", {24'd0, remainder}, 32'd2);

    // divide by zero
    @(negedge clk);
    issue(1'b0, 8'd50, 8'd0);
    wait_done(lat, bcnt);
`ifdef DIV_ZERO_CHECK_EN
    chk("dbz_latency", lat, 32'd1);
    chk("dbz_quo", {24'd0, quotient}, 32'hFF);
    chk("dbz_rem", {24'd0, remainder}, 32'd50);
    chk("dbz_flag", {31'd0, div_by_zero}, 32'd1);
    @(negedge clk);
    issue(1'b0, 8'd100, 8'd7);
    chk("dbz_cleared", {31'd0, div_by_zero}, 32'd0);
    wait_done(lat2, bcnt);
    chk("dbz_next_latency", lat2, 32'd9);
    chk("dbz_next_quo", {24'd0, quotient}, 32'd14);
`else
    chk("dbz_latency", lat, 32'd9);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
